// File: rtl/comm_frame_seq.sv
// Three-byte command framer for a UART link: sends {cmd, data[15:8], data[7:0]},
// then waits for a single response byte or times out after TMO_CYC cycles.
module comm_frame_seq #(
  parameter logic [23:0] TMO_CYC = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        frm_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  input  logic        clr_resp_rdy,
  output logic        resp_tmo,
  output logic        busy
);

  localparam int CNT_W = (TMO_CYC > 24'd2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 24'd1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TX_CMD    = 3'd1;
  localparam logic [2:0] TX_HI     = 3'd2;
  localparam logic [2:0] TX_LO     = 3'd3;
  localparam logic [2:0] WAIT_RESP = 3'd4;

  logic [2:0]       state;
  logic [15:0]      data_r;
  logic [CNT_W-1:0] cnt;
  logic             rx_take;

  // rx_rdy is still high in the cycle our clear pulse is out; don't take it twice
  assign rx_take = rx_rdy & ~clr_rx_rdy;
  assign busy    = (state != IDLE);

  // tx_data doubles as the captured command byte: it is loaded on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_r     <= 16'h0000;
      cnt        <= '0;
      tx_data    <= 8'h00;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      frm_snt    <= 1'b0;
      resp_rdy   <= 1'b0;
      resp       <= 8'h00;
      resp_tmo   <= 1'b0;
    end else begin
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      if (clr_resp_rdy)
        resp_rdy <= 1'b0;
      if (rx_take && state != WAIT_RESP)
        clr_rx_rdy <= 1'b1;
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            data_r   <= data;
            tx_data  <= cmd;
            trmt     <= 1'b1;
            frm_snt  <= 1'b0;
            resp_rdy <= 1'b0;
            resp_tmo <= 1'b0;
            state    <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (tx_done) begin
            tx_data <= data_r[15:8];
            trmt    <= 1'b1;
            state   <= TX_HI;
          end
        end
        TX_HI: begin
          if (tx_done) begin
            tx_data <= data_r[7:0];
            trmt    <= 1'b1;
            state   <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_done) begin
            frm_snt <= 1'b1;
            cnt     <= '0;
            state   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // a byte arriving in the timeout cycle still counts as a response
          if (rx_take) begin
            resp       <= rx_data;
            resp_rdy   <= 1'b1;
            clr_rx_rdy <= 1'b1;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            resp_tmo <= 1'b1;
            state    <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_frame_seq.sv
// Bench for comm_frame_seq: directed scenarios plus randomized frames checked
// against a byte-queue / cycle-count model of the framing and response rules.
module tb_comm_frame_seq;

  localparam logic [23:0] TMO = 24'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_resp_rdy = 1'b0;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        clr_rx_rdy;
  logic        frm_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        resp_tmo;
  logic        busy;

  int         total = 0;
  int         bad = 0;
  int         tx_dly = 10;
  int         cd = 0;
  int         trmt_n = 0;
  int         clr_n = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_resp = 8'h00;

  comm_frame_seq #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .resp_tmo(resp_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  // UART transmitter model: records every trmt byte, answers tx_done tx_dly cycles later
  always @(negedge clk) begin
    if (rst) begin
      cd = 0;
      tx_done = 1'b0;
    end else begin
      if (tx_done) tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
      if (trmt) begin
        tx_q.push_back(tx_data);
        trmt_n++;
        cd = tx_dly;
      end
      if (clr_rx_rdy) clr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [15:0] d, input bit clr_q);
    tick();
    if (clr_q) tx_q.delete();
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
  endtask

  task automatic wait_frm();
    int n = 0;
    while (!frm_snt && n < 300) begin
      tick();
      n++;
    end
    check("frm_snt", frm_snt, 1);
  endtask

  task automatic wait_q(input int sz);
    int n = 0;
    while (tx_q.size() < sz && n < 100) begin
      tick();
      n++;
    end
    check("tx_progress", tx_q.size(), sz);
  endtask

  task automatic wait_tmo(output int n);
    n = 0;
    while (!resp_tmo && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] c, input logic [15:0] d);
    logic [7:0] exp_b[3];
    exp_b[0] = c;
    exp_b[1] = d[15:8];
    exp_b[2] = d[7:0];
    check({tag, "_nbytes"}, tx_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_byte%0d", tag, i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_b[i]);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_rdy = 1'b1;
    tick();
    while (!clr_rx_rdy && n < 5) begin
      tick();
      n++;
    end
    check("clr_rx_rdy_seen", clr_rx_rdy, 1);
    rx_rdy = 1'b0;
  endtask

  initial begin
    int n;
    int mode;
    int dly;
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  b;

    // reset state
    tick();
    tick();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_trmt", trmt, 0);
    check("rst_clr_rx", clr_rx_rdy, 0);
    check("rst_frm_snt", frm_snt, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_tmo", resp_tmo, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // basic frame and response
    trmt_n = 0;
    send(8'h02, 16'h003A, 1);
    check("basic_busy", busy, 1);
    wait_frm();
    check_frame("basic", 8'h02, 16'h003A);
    check("basic_trmt_n", trmt_n, 3);
    repeat (5) tick();
    check("basic_busy_wait", busy, 1);
    check("basic_frm_hold", frm_snt, 1);
    clr_n = 0;
    rx_byte(8'hA5);
    exp_resp = 8'hA5;
    check("resp_val", resp, 8'hA5);
    check("resp_rdy_set", resp_rdy, 1);
    check("resp_busy", busy, 0);
    tick();
    check("clr_rx_width", clr_rx_rdy, 0);
    check("clr_rx_count", clr_n, 1);
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    check("resp_rdy_clr", resp_rdy, 0);

    // timeout
    send(8'h11, 16'h2233, 1);
    wait_frm();
    wait_tmo(n);
    check("tmo_cycles", n, 100);
    check("tmo_flag", resp_tmo, 1);
    check("tmo_resp_hold", resp, exp_resp);
    check("tmo_busy", busy, 0);
    check("tmo_frm_hold", frm_snt, 1);
    send(8'h12, 16'h3456, 1);
    check("tmo_cleared", resp_tmo, 0);
    check("frm_snt_cleared", frm_snt, 0);
    wait_frm();
    check_frame("after_tmo", 8'h12, 16'h3456);
    rx_byte(8'h5A);
    exp_resp = 8'h5A;
    check("after_tmo_resp", resp, 8'h5A);

    // busy ignore and stray rx byte
    trmt_n = 0;
    send(8'h02, 16'h003A, 1);
    rx_byte(8'h77);
    check("stray_resp_rdy", resp_rdy, 0);
    check("stray_resp", resp, exp_resp);
    check("stray_busy", busy, 1);
    wait_q(2);
    send(8'h05, 16'hFFFF, 0);
    wait_frm();
    check_frame("ignore", 8'h02, 16'h003A);
    check("ignore_trmt_n", trmt_n, 3);
    rx_byte(8'hA5);
    exp_resp = 8'hA5;

    // asynchronous reset mid-frame
    send(8'h09, 16'h1234, 1);
    wait_q(2);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_trmt", trmt, 0);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_resp", resp, 8'h00);
    check("arst_resp_rdy", resp_rdy, 0);
    check("arst_frm_snt", frm_snt, 0);
    check("arst_resp_tmo", resp_tmo, 0);
    exp_resp = 8'h00;
    tick();
    tx_q.delete();
    trmt_n = 0;
    rst = 1'b0;
    cmd = 8'h08;
    data = 16'h0000;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    check("post_rst_busy", busy, 1);
    wait_frm();
    check_frame("post_rst", 8'h08, 16'h0000);
    check("post_rst_trmt_n", trmt_n, 3);
    rx_byte(8'hC3);
    exp_resp = 8'hC3;

    // set and clear of resp_rdy in the same cycle
    send(8'h21, 16'h0001, 1);
    wait_frm();
    rx_data = 8'hE1;
    rx_rdy = 1'b1;
    clr_resp_rdy = 1'b1;
    tick();
    clr_resp_rdy = 1'b0;
    rx_rdy = 1'b0;
    exp_resp = 8'hE1;
    check("coll_clr_rx", clr_rx_rdy, 1);
    check("coll_resp_rdy", resp_rdy, 1);
    check("coll_resp", resp, 8'hE1);

    // response arriving in the timeout cycle
    send(8'h22, 16'h0002, 1);
    wait_frm();
    repeat (99) tick();
    check("edge_pre_tmo", resp_tmo, 0);
    rx_data = 8'h3C;
    rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    exp_resp = 8'h3C;
    check("edge_tmo", resp_tmo, 0);
    check("edge_resp", resp, 8'h3C);
    check("edge_resp_rdy", resp_rdy, 1);
    check("edge_busy", busy, 0);
    tick();
    check("edge_tmo_late", resp_tmo, 0);

    // randomized frames
    for (int it = 0; it < 10; it++) begin
      c = 8'($urandom);
      d = 16'($urandom);
      tx_dly = $urandom_range(1, 12);
      mode = $urandom_range(0, 3);
      trmt_n = 0;
      send(c, d, 1);
      check("rnd_tmo_clr", resp_tmo, 0);
      check("rnd_rdy_clr", resp_rdy, 0);
      wait_frm();
      check_frame("rnd", c, d);
      check("rnd_trmt_n", trmt_n, 3);
      if (mode == 0) begin
        wait_tmo(n);
        check("rnd_tmo_cycles", n, 100);
        check("rnd_tmo_resp", resp, exp_resp);
      end else begin
        dly = $urandom_range(0, 90);
        repeat (dly) tick();
        b = 8'($urandom);
        rx_byte(b);
        exp_resp = b;
        check("rnd_resp", resp, b);
        check("rnd_resp_rdy", resp_rdy, 1);
        check("rnd_no_tmo", resp_tmo, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
